// File: rtl/mac_dot_seq_if.sv
// Operand-stream and result handshake bundle for the time-shared 3x3 MAC sequencer.
// The slave side is the sequencer. The master side is the operand producer and result consumer.
interface mac_dot_seq_if #(
  parameter int W    = 5,
  parameter int ACCW = 14
);
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_sum;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/mac_dot_seq.sv
// Loads TAPS operand pairs, then runs one shared multiplier over them at one tap per cycle.
// Returns the unsigned dot product through a valid/ready result handshake.
module mac_dot_seq #(
  parameter int W    = 5,
  parameter int TAPS = 9,
  parameter int ACCW = 14
) (
  input  logic        clk,
  input  logic        rst,
  mac_dot_seq_if.slave io,
  output logic        busy,
  output logic [3:0]  tap_idx
);

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(TAPS - 1);

  state_t          state, state_nxt;
  logic [W-1:0]    tap_a [TAPS];
  logic [W-1:0]    tap_b [TAPS];
  logic [3:0]      idx_nxt;
  logic [ACCW-1:0] acc, acc_nxt, sum_nxt;
  logic            busy_nxt;
  logic            tap_we;

  // Full 2W-bit unsigned product, zero-extended to the accumulator width.
  function automatic logic [ACCW-1:0] mul_ext(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return {{(ACCW-2*W){1'b0}}, p};
  endfunction

  assign io.in_ready  = (state == LOAD);
  assign io.out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = tap_idx;
    acc_nxt   = acc;
    sum_nxt   = io.out_sum;
    tap_we    = 1'b0;
    case (state)
      LOAD: begin
        if (io.in_valid) begin
          tap_we = 1'b1;
          if (tap_idx == LAST) begin
            state_nxt = RUN;
            idx_nxt   = 4'd0;
            acc_nxt   = '0;
          end else begin
            idx_nxt = tap_idx + 4'd1;
          end
        end
      end
      RUN: begin
        acc_nxt = acc + mul_ext(tap_a[tap_idx], tap_b[tap_idx]);
        if (tap_idx == LAST) begin
          // Index parks on the last tap so DONE reports TAPS-1.
          sum_nxt   = acc_nxt;
          state_nxt = DONE;
        end else begin
          idx_nxt = tap_idx + 4'd1;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_nxt = LOAD;
          idx_nxt   = 4'd0;
        end
      end
      default: state_nxt = LOAD;
    endcase
    busy_nxt = (state_nxt != LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      tap_idx    <= 4'd0;
      acc        <= '0;
      io.out_sum <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      tap_idx    <= idx_nxt;
      acc        <= acc_nxt;
      io.out_sum <= sum_nxt;
      busy       <= busy_nxt;
    end
  end

  // Tap storage is pure data: no reset, written only on accepted beats.
  always_ff @(posedge clk) begin
    if (!rst && tap_we) begin
      tap_a[tap_idx] <= io.in_a;
      tap_b[tap_idx] <= io.in_b;
    end
  end

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
- Sequencer for the 3x3 multiply-accumulate datapath.
- Accepts a serial stream of nine 5-bit operand pairs (a, b) through a valid/ready handshake and stores them in an internal tap buffer.
- Runs one shared multiplier over the stored taps, one tap per cycle, and returns the 9-term dot product through a valid/ready output handshake.
- Replaces nine parallel multipliers with one time-shared unit for area-limited builds.

Parameters:
- W, 5: operand width of a and b (unsigned).
- TAPS, 9: number of operand pairs per dot product (3x3 window).
- ACCW, 14: accumulator/result width. Must be >= 2*W + ceil(log2(TAPS)). 14 holds 9*31*31 = 8649.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair on in_a/in_b is valid.
- in_ready  out  1  block accepts a pair this cycle.
- in_a  in  W  operand a (unsigned).
- in_b  in  W  operand b (unsigned).
- out_valid  out  1  out_sum holds a completed result.
- out_ready  in  1  consumer takes the result this cycle.
- out_sum  out  ACCW  dot product sum over k of a[k]*b[k].
- busy  out  1  high in RUN and DONE.
- tap_idx  out  4  current load index (LOAD) or current compute index (RUN).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state = LOAD, load count = 0, tap_idx = 0, accumulator = 0, out_sum = 0, out_valid = 0, busy = 0, in_ready = 1. Tap buffer contents are don't-care after reset.
- rst overrides everything, including a reset asserted mid-LOAD, mid-RUN or in DONE. A partial window or pending result is discarded with no output.
- States: LOAD, RUN, DONE. All outputs are registered, except in_ready and out_valid, which are decoded directly from the state register.
- LOAD:
  - in_ready = 1.
  - On an edge with in_valid = 1, the pair is written to buffer[cnt] and cnt increments.
  - When the accepted pair is the last one (cnt = TAPS-1): accumulator is cleared, tap_idx is set to 0, state goes to RUN.
  - in_valid = 0 means hold, with no change to state or buffer.
- RUN:
  - in_ready = 0. in_valid is ignored and no pair is accepted.
  - Each edge: accumulator += buffer[tap_idx].a * buffer[tap_idx].b. The product is a full 2W-bit unsigned value, zero-extended to ACCW. No saturation; overflow cannot occur under the ACCW rule.
  - tap_idx increments each edge.
  - On the edge that adds tap TAPS-1: out_sum is loaded with the final sum and state goes to DONE.
- Latency: out_valid is high in the cycle that follows exactly TAPS edges after the edge that accepted the last pair (9 cycles at default).
- DONE:
  - out_valid = 1. out_sum is stable until the handshake completes.
  - When out_ready = 1: state goes to LOAD, cnt = 0, tap_idx = 0.
  - When out_ready = 0: hold indefinitely with no timeout.
  - in_ready = 0 throughout DONE.
- No overlap between windows: a new window can only be accepted from the cycle after the output handshake. Back-to-back throughput is TAPS (load) + TAPS (run) + 1 (done) cycles minimum per result.
- Buffer contents persist until overwritten by the next LOAD.
- out_sum holds its last value after the handshake until the next result is loaded.
- busy = 1 in RUN and DONE, 0 in LOAD.
- tap_idx shows cnt in LOAD, the compute index in RUN, and TAPS-1 in DONE.

Test Plan:
- Reset, then nine pairs a = 4, b = 1 with in_valid held high and out_ready = 1. Required: in_ready drops after the 9th accept, out_valid rises exactly 9 cycles later with out_sum = 36, then the block returns to LOAD with in_ready = 1.
- Maximum values: nine pairs a = 31, b = 31. Required: out_sum = 8649 with no wrap. Distinct pairs a = k+1, b = 9-k for k = 0..8. Required: out_sum = 165.
- Gapped input and backpressure: pairs delivered with in_valid low on alternate cycles, out_ready held low for 5 cycles in DONE. Required: only valid beats are counted, out_valid and out_sum stay stable while stalled, and exactly one handshake occurs when out_ready rises.
- Pairs driven during RUN/DONE: in_valid = 1 with a = 31, b = 31 while busy = 1. Required: in_ready = 0, the result is unaffected, and the buffer is not overwritten.
- Reset mid-operation: assert rst for 1 cycle after 4 pairs loaded, then separately at RUN tap_idx = 5. Required: next cycle state = LOAD, out_valid = 0, out_sum = 0. A fresh window of a = 2, b = 3 then gives out_sum = 54.
- Two back-to-back windows (a = 1, b = 1, then a = 2, b = 2) with out_ready = 1. Required: results 9 and 36, and the accumulator is cleared between windows.
